data_ram_resp: RTL and testbench
================================

// Module: data_ram_resp
// PURPOSE
// - Data-memory responder for the load/store path of the MEM stage: accepts one word request
//   (read or byte-masked write) from the initiator and completes it after a programmable wait.
// - Raises a stall request toward the pipeline controller while a request is pending.
// - Pulses a one-cycle ready when the request completes.
// - Sits between mem and the mem/wb register; wait states model slow on-chip or external RAM.
// PARAMETERS
// - ADDR_W       17  word-address bits; depth = 2**ADDR_W words
// - WAIT_CYCLES   2  cycles spent in WAIT before the response cycle; 0..15 legal
// PORTS
// - clk         in   1   single clock; all state updates on the rising edge
// - rst         in   1   asynchronous, active-low reset
// - mem_ce_i    in   1   request valid; initiator holds it high until it sees mem_ready_o
// - mem_we_i    in   1   1 = write, 0 = read
// - mem_addr_i  in   32  byte address; bits [ADDR_W+1:2] form the word index, all other bits ignored
// - mem_sel_i   in   4   byte enables; sel[i] controls data bits [8i+7:8i]
// - mem_data_i  in   32  write data
// - mem_data_o  out  32  read data; valid when mem_ready_o=1 for a read
// - mem_ready_o out  1   one-cycle completion pulse
// - stallreq_o  out  1   pipeline stall request
// BEHAVIOUR
// - FSM states are IDLE, WAIT and RESP.
// - IDLE:
//   - If mem_ce_i=1, latch we, word index, sel and data at the edge.
//   - Load the wait counter with WAIT_CYCLES.
//   - Go to WAIT, or go straight to RESP when WAIT_CYCLES=0.
// - WAIT: decrement the counter each cycle; when it reaches 1, go to RESP at that edge.
// - RESP:
//   - mem_ready_o=1 for exactly one cycle.
//   - Go to IDLE unconditionally.
//   - mem_ce_i seen during RESP belongs to the current request and is never re-accepted.
// - Latency: a request first presented in cycle N gets mem_ready_o=1 in cycle N+WAIT_CYCLES+1.
// - Throughput: at most one request per WAIT_CYCLES+2 cycles, because IDLE always separates requests.
// - Read:
//   - The word at the latched index is registered into mem_data_o at the edge entering RESP.
//   - A read returns the full word; sel is ignored.
//   - mem_data_o holds its value until the next completed read.
// - Write:
//   - The array is updated at the edge that ends RESP, and only for lanes with sel=1.
//   - sel=4'b0000 writes nothing but still completes with ready.
//   - A read in the cycle after a write RESP returns the new data.
// - stallreq_o = mem_ce_i & ~mem_ready_o, combinational.
//   - It is 0 in IDLE when ce=0.
//   - It is 1 in the request cycle and throughout WAIT.
//   - It is 0 in RESP, so the pipeline advances at the RESP edge.
// - The latched request is authoritative: changes to the inputs after acceptance are ignored.
// - If mem_ce_i drops during WAIT, the request still completes and ready still pulses.
// - Reset (rst=0), at any time including mid-operation:
//   - State goes to IDLE and the counter to 0.
//   - mem_ready_o=0, mem_data_o=32'h0000_0000.
//   - stallreq_o follows its equation.
//   - A write whose RESP cycle is cut by reset is not committed.
//   - Array contents are not reset.
// - Out-of-range upper address bits alias; alignment is checked upstream, not here.
// STRUCTURE
// - Shared define file: Zero_Word, Chip_Enable/Disable, Write_Enable/Disable, the sel width
//   constant and the FSM state encodings.
// - Sub-module dram_byte_lane (x4): ADDR_W x 8 synchronous RAM with a write enable and a
//   registered read.
// - The FSM, counter and lane enables live in data_ram_resp.
// TESTING
// - Reset then idle:
//   - Stimulus: rst=0 for 3 cycles, then rst=1 with ce=0.
//   - Required: ready=0, stallreq=0, data_o=0 throughout.
// - Full-word write then read, WAIT_CYCLES=2:
//   - Stimulus: write 0xDEADBEEF, sel=4'hF, to addr 0x10; then read addr 0x10.
//   - Required: each ready arrives 3 cycles after the request, and the read returns 0xDEADBEEF.
// - Byte-masked write:
//   - Stimulus: addr 0x10 holds 0xDEADBEEF; write 0x11223344 with sel=4'b0101.
//   - Required: a read returns 0xDE22BE44; a sel=0 write leaves the word unchanged but still
//     gives ready.
// - Stall timing:
//   - Stimulus: hold ce=1 for one request.
//   - Required: stallreq is 1 for exactly WAIT_CYCLES+1 cycles, then 0 in the ready cycle;
//     with WAIT_CYCLES=0, stallreq is 1 for 1 cycle.
// - Input corruption after accept:
//   - Stimulus: change addr and data, and drop ce, while in WAIT.
//   - Required: the originally latched write lands at the original address, and ready pulses once.
// - Reset mid-operation:
//   - Stimulus: assert rst during the RESP cycle of a write to addr 0x20 holding 0x0.
//   - Required: the word stays 0x0, ready=0 immediately, and the next request completes normally.

Source files
------------

// File: rtl/data_ram_resp_pkg.sv
// Shared constants, lane geometry and FSM encoding for the MEM-stage data RAM responder.
// Imported by the responder top and its byte-lane RAM.
package data_ram_resp_pkg;

  localparam logic [31:0] Zero_Word     = 32'h0000_0000;
  localparam logic        Chip_Enable   = 1'b1;
  localparam logic        Chip_Disable  = 1'b0;
  localparam logic        Write_Enable  = 1'b1;
  localparam logic        Write_Disable = 1'b0;

  localparam int Sel_W  = 4;
  localparam int Lane_W = 8;
  localparam int Cnt_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dram_byte_lane.sv
// One 8-bit lane of the data RAM: synchronous write plus an enabled, registered read port.
// Only the read register is reset; the array contents survive reset.
module dram_byte_lane
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [Lane_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [Lane_W-1:0] rd_data_o
);

  localparam int Depth = 2 ** ADDR_W;

  logic [Lane_W-1:0] ram [Depth];
  logic [Lane_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      ram[wr_addr_i] <= wr_data_i;
    end
  end

  // The read register holds between reads so the last loaded word stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= ram[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_ram_resp.sv
// MEM-stage data RAM responder: accepts one read or byte-masked write, waits WAIT_CYCLES,
// then pulses mem_ready_o for one cycle while stalling the pipeline in between.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_ce_i,
  input  logic             mem_we_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [Sel_W-1:0] mem_sel_i,
  input  logic [31:0]      mem_data_i,
  output logic [31:0]      mem_data_o,
  output logic             mem_ready_o,
  output logic             stallreq_o
);

  localparam logic [Cnt_W-1:0] Wait_Load = Cnt_W'(WAIT_CYCLES);
  localparam logic [Cnt_W-1:0] Cnt_Last  = Cnt_W'(1);

  state_e            state_q, state_d;
  logic [Cnt_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [Sel_W-1:0]  sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_idx;
  logic [Sel_W-1:0]  lane_we;
  logic [Sel_W-1:0][Lane_W-1:0] lane_rd;
  logic              unused_addr_bits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_ce_i != Chip_Disable) begin
          we_d    = mem_we_i;
          idx_d   = mem_addr_i[ADDR_W+1:2];
          sel_d   = mem_sel_i;
          wdata_d = mem_data_i;
          cnt_d   = Wait_Load;
          // With no wait states the read must be launched straight from the live address.
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            rd_en   = (mem_we_i == Write_Disable);
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= Cnt_Last) begin
          state_d = RESP;
          cnt_d   = '0;
          rd_en   = (we_q == Write_Disable);
        end else begin
          cnt_d = cnt_q - Cnt_Last;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= Write_Disable;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= Zero_Word;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_ready_o = (state_q == RESP);
  assign stallreq_o  = (mem_ce_i == Chip_Enable) & ~mem_ready_o;
  assign rd_idx      = (state_q == IDLE) ? mem_addr_i[ADDR_W+1:2] : idx_q;

  // Upper address bits alias and the byte offset is checked upstream.
  assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  // Writes commit on the edge that ends RESP, so a reset during RESP drops them.
  generate
    for (genvar gi = 0; gi < Sel_W; gi++) begin : g_lane
      assign lane_we[gi] = (state_q == RESP) && (we_q == Write_Enable) && sel_q[gi];

      dram_byte_lane #(
        .ADDR_W (ADDR_W)
      ) u_lane (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (lane_we[gi]),
        .wr_addr_i (idx_q),
        .wr_data_i (wdata_q[gi*Lane_W +: Lane_W]),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_idx),
        .rd_data_o (lane_rd[gi])
      );

      assign mem_data_o[gi*Lane_W +: Lane_W] = lane_rd[gi];
    end
  endgenerate

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp: dut0 runs with two wait states, dut1 with none.
// Read expectations are queued at issue and popped when mem_ready_o pulses.
module tb_data_ram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce0, ce1, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1, stall0, stall1;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mdl0 [int];
  logic [31:0] mdl1 [int];

  always #5 clk = ~clk;

  data_ram_resp #(.ADDR_W(17), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .mem_ce_i(ce0), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rdata0),
    .mem_ready_o(rdy0), .stallreq_o(stall0)
  );

  data_ram_resp #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .mem_ce_i(ce1), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rdata1),
    .mem_ready_o(rdy1), .stallreq_o(stall1)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // Entered and left on a falling edge; the request cycle is cycle 0.
  task automatic do_req(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] v);
    int          lat, stall_cnt, idx, ready_at;
    bit          got;
    logic        r, st;
    logic [31:0] q, cur, e;
    lat = (d == 0) ? 2 : 0;
    idx = int'(a[31:2]);
    if (d == 0) cur = mdl0.exists(idx) ? mdl0[idx] : 32'h0;
    else        cur = mdl1.exists(idx) ? mdl1[idx] : 32'h0;
    if (w) begin
      if (d == 0) mdl0[idx] = merge(cur, v, s);
      else        mdl1[idx] = merge(cur, v, s);
    end else begin
      exp_q.push_back(cur);
    end
    we = w; addr = a; sel = s; wdata = v;
    if (d == 0) ce0 = 1'b1; else ce1 = 1'b1;
    got = 0; stall_cnt = 0; ready_at = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      r  = (d == 0) ? rdy0 : rdy1;
      st = (d == 0) ? stall0 : stall1;
      q  = (d == 0) ? rdata0 : rdata1;
      if (r === 1'b1) begin
        got = 1; ready_at = k;
        total++;
        if (k != lat + 1) begin
          bad++; $display("FAIL latency dut%0d: got %0d want %0d", d, k, lat + 1);
        end
        total++;
        if (st !== 1'b0) begin
          bad++; $display("FAIL stall_in_ready dut%0d: got %b want 0", d, st);
        end
        total++;
        if (stall_cnt != lat + 1) begin
          bad++; $display("FAIL stall_len dut%0d: got %0d want %0d", d, stall_cnt, lat + 1);
        end
        if (!w) begin
          e = exp_q.pop_front();
          total++;
          if (q !== e) begin
            bad++; $display("FAIL read_data dut%0d addr=%h: got %h want %h", d, a, q, e);
          end
        end
      end else if (st === 1'b1) begin
        stall_cnt++;
      end
      @(negedge clk);
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL ready_timeout dut%0d: got none want pulse", d);
    end
    ce0 = 1'b0; ce1 = 1'b0;
    $display("txn dut%0d %s addr=%h sel=%h wdata=%h ready_cycle=%0d", d, w ? "WR" : "RD",
             a, s, v, ready_at);
  endtask

  task automatic test_reset();
    rst = 1'b1; ce0 = 0; ce1 = 0; we = 0; addr = 0; sel = 0; wdata = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) rst = 1'b1;
      #1;
      total++;
      if ({rdy0, stall0, rdata0, rdy1, stall1, rdata1} !== 66'h0) begin
        bad++;
        $display("FAIL reset_idle cycle%0d: got rdy=%b%b stall=%b%b d0=%h d1=%h want all 0",
                 c, rdy0, rdy1, stall0, stall1, rdata0, rdata1);
      end
      @(negedge clk);
    end
    $display("txn reset/idle sequence done");
  endtask

  task automatic test_full_word();
    do_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    do_req(0, 1'b0, 32'h10, 4'h0, 32'h0);
  endtask

  task automatic test_byte_mask();
    do_req(0, 1'b1, 32'h10, 4'b0101, 32'h11223344);
    do_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
    do_req(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
    do_req(0, 1'b0, 32'h10, 4'h0, 32'h0);
  endtask

  task automatic test_zero_wait();
    do_req(1, 1'b1, 32'h8, 4'hF, 32'h01234567);
    do_req(1, 1'b0, 32'h8, 4'h0, 32'h0);
    do_req(1, 1'b1, 32'h8, 4'b1010, 32'hAABBCCDD);
    do_req(1, 1'b0, 32'h8, 4'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b1, 32'h40 + 32'(i * 4), 4'hF, $urandom);
      do_req(0, 1'b0, 32'h40 + 32'(i * 4), 4'h0, 32'h0);
    end
  endtask

  task automatic test_corrupt();
    int pulses;
    do_req(0, 1'b1, 32'h34, 4'hF, 32'h55AA55AA);
    mdl0[int'(32'h30 >> 2)] = 32'hCAFEF00D;
    we = 1'b1; addr = 32'h30; sel = 4'hF; wdata = 32'hCAFEF00D; ce0 = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 32'h34; sel = 4'h3; wdata = 32'h0BADBEEF; ce0 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (rdy0 === 1'b1) pulses++;
      @(negedge clk);
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL corrupt_ready_count: got %0d want 1", pulses);
    end
    $display("txn dut0 WR addr=00000030 (inputs changed in WAIT) pulses=%0d", pulses);
    do_req(0, 1'b0, 32'h30, 4'h0, 32'h0);
    do_req(0, 1'b0, 32'h34, 4'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_req(0, 1'b1, 32'h20, 4'hF, 32'h0);
    we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'hFFFFFFFF; ce0 = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rdy0 === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL reset_mid_no_resp: got none want ready");
    end
    rst = 1'b0;
    #1;
    total++;
    if (rdy0 !== 1'b0) begin
      bad++; $display("FAIL reset_mid_ready: got %b want 0", rdy0);
    end
    total++;
    if (rdata0 !== 32'h0) begin
      bad++; $display("FAIL reset_mid_data: got %h want 00000000", rdata0);
    end
    total++;
    if (stall0 !== 1'b1) begin
      bad++; $display("FAIL reset_mid_stall: got %b want 1", stall0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; ce0 = 1'b0;
    $display("txn dut0 WR addr=00000020 cut by reset");
    do_req(0, 1'b0, 32'h20, 4'h0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) do_req(0, 1'b1, 32'h100 + 32'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < 12; i++) begin
      do_req(0, 1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7) * 4),
             4'($urandom_range(0, 15)), $urandom);
    end
    for (int i = 0; i < 8; i++) do_req(0, 1'b0, 32'h100 + 32'(i * 4), 4'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; ce0 = 0; ce1 = 0; we = 0; addr = 0; sel = 0; wdata = 0;
    test_reset();
    test_full_word();
    test_byte_mask();
    test_zero_wait();
    test_back_to_back();
    test_corrupt();
    test_reset_mid();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
